// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants, scheduler state type and byte-order helpers
package sha256_pkg;
    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [63:0] HDR_LEN_BITS = 64'd640;
    localparam logic [63:0] DIG_LEN_BITS = 64'd256;
    typedef enum logic [3:0] {
        IDLE, MID_START, MID_WAIT, T_START, T_WAIT, D_START, D_WAIT, CHECK, DRAIN
    } state_t;
    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction
    function automatic logic [255:0] bswap256(input logic [255:0] x);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
        return r;
    endfunction
endpackage

// File: rtl/sha256_block_fmt.sv
// sha256_block_fmt: builds the padded message block and chaining input for each core operation
module sha256_block_fmt
    import sha256_pkg::*;
(
    input  state_t         state,
    input  logic [607:0]   hdr,
    input  logic [31:0]    nonce,
    input  logic [255:0]   midstate,
    input  logic [255:0]   digest1,
    output logic [511:0]   block,
    output logic [255:0]   hin
);
    logic w_mid, w_t, w_d;
    assign w_mid = state == MID_START;
    assign w_t   = state == T_START;
    assign w_d   = state == D_START;
    // hdr holds header bytes 0..75; the nonce field is substituted here
    assign block = w_mid ? hdr[607:96] :
                   w_t   ? {hdr[95:0], bswap32(nonce), 1'b1, 319'b0, HDR_LEN_BITS} :
                   w_d   ? {digest1, 1'b1, 191'b0, DIG_LEN_BITS} : '0;
    assign hin   = w_t ? midstate : (w_mid || w_d) ? SHA256_IV : '0;
endmodule

// File: rtl/sha256_nonce_scheduler.sv
// sha256_nonce_scheduler: sequences a shared SHA-256 core through a double-hash nonce search
module sha256_nonce_scheduler
    import sha256_pkg::*;
#(
    parameter int NONCE_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                go,
    input  logic                abort,
    input  logic [639:0]        header,
    input  logic [NONCE_W-1:0]  nonce_start,
    input  logic [NONCE_W-1:0]  nonce_end,
    input  logic [255:0]        target,
    output logic                core_start,
    output logic [511:0]        core_block,
    output logic [255:0]        core_hin,
    input  logic                core_done,
    input  logic [255:0]        core_hout,
    output logic                busy,
    output logic                found,
    output logic                exhausted,
    output logic [NONCE_W-1:0]  found_nonce,
    output logic [255:0]        found_hash,
    output logic [31:0]         hash_count
);
    state_t r_state, w_state_n;
    logic [607:0] r_header, w_header_n;
    logic [NONCE_W-1:0] r_nonce, w_nonce_n, r_nonce_end, w_nonce_end_n, w_found_nonce_n;
    logic [255:0] r_target, w_target_n, r_midstate, w_midstate_n, r_digest1, w_digest1_n;
    logic [255:0] r_digest2, w_digest2_n, w_found_hash_n, w_hash_final, w_hin;
    logic [511:0] w_block;
    logic [31:0] w_hash_count_n;
    logic w_found_n, w_exhausted_n, w_hit, w_is_start, w_unused_nonce_field;
    assign w_unused_nonce_field = ^header[31:0];
    assign w_hash_final = bswap256(r_digest2);
    assign w_hit = w_hash_final <= r_target;
    assign w_is_start = w_state_n inside {MID_START, T_START, D_START};
    always_comb begin
        w_state_n = r_state;
        w_header_n = r_header;
        w_nonce_n = r_nonce;
        w_nonce_end_n = r_nonce_end;
        w_target_n = r_target;
        w_midstate_n = r_midstate;
        w_digest1_n = r_digest1;
        w_digest2_n = r_digest2;
        w_found_n = found;
        w_exhausted_n = exhausted;
        w_found_nonce_n = found_nonce;
        w_found_hash_n = found_hash;
        w_hash_count_n = hash_count;
        case (r_state)
            IDLE: if (go && !abort) begin
                w_header_n = header[639:32];
                w_nonce_n = nonce_start;
                w_nonce_end_n = nonce_end;
                w_target_n = target;
                w_found_n = 1'b0;
                w_exhausted_n = 1'b0;
                w_hash_count_n = '0;
                w_state_n = MID_START;
            end
            MID_START: w_state_n = abort ? IDLE : MID_WAIT;
            T_START:   w_state_n = abort ? IDLE : T_WAIT;
            D_START:   w_state_n = abort ? IDLE : D_WAIT;
            MID_WAIT: if (abort) w_state_n = core_done ? IDLE : DRAIN;
                else if (core_done) begin
                    w_midstate_n = core_hout;
                    w_state_n = T_START;
                end
            T_WAIT: if (abort) w_state_n = core_done ? IDLE : DRAIN;
                else if (core_done) begin
                    w_digest1_n = core_hout;
                    w_state_n = D_START;
                end
            D_WAIT: if (abort) w_state_n = core_done ? IDLE : DRAIN;
                else if (core_done) begin
                    w_digest2_n = core_hout;
                    w_state_n = CHECK;
                end
            CHECK: if (abort) w_state_n = IDLE;
                else begin
                    w_hash_count_n = hash_count + 32'd1;
                    if (w_hit) begin
                        w_found_n = 1'b1;
                        w_found_nonce_n = r_nonce;
                        w_found_hash_n = w_hash_final;
                        w_state_n = IDLE;
                    end else if (r_nonce == r_nonce_end) begin
                        w_exhausted_n = 1'b1;
                        w_state_n = IDLE;
                    end else begin
                        w_nonce_n = r_nonce + 1'b1;
                        w_state_n = T_START;
                    end
                end
            DRAIN: w_state_n = core_done ? IDLE : DRAIN;
            default: w_state_n = IDLE;
        endcase
    end
    // formatter sees next-cycle values so block/hin are valid alongside core_start
    sha256_block_fmt u_fmt (
        .state    (w_state_n),
        .hdr      (w_header_n),
        .nonce    (w_nonce_n),
        .midstate (w_midstate_n),
        .digest1  (w_digest1_n),
        .block    (w_block),
        .hin      (w_hin)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_header <= '0;
            r_nonce <= '0;
            r_nonce_end <= '0;
            r_target <= '0;
            r_midstate <= '0;
            r_digest1 <= '0;
            r_digest2 <= '0;
            core_start <= 1'b0;
            core_block <= '0;
            core_hin <= '0;
            busy <= 1'b0;
            found <= 1'b0;
            exhausted <= 1'b0;
            found_nonce <= '0;
            found_hash <= '0;
            hash_count <= '0;
        end else begin
            r_state <= w_state_n;
            r_header <= w_header_n;
            r_nonce <= w_nonce_n;
            r_nonce_end <= w_nonce_end_n;
            r_target <= w_target_n;
            r_midstate <= w_midstate_n;
            r_digest1 <= w_digest1_n;
            r_digest2 <= w_digest2_n;
            core_start <= w_is_start;
            core_block <= w_is_start ? w_block : core_block;
            core_hin <= w_is_start ? w_hin : core_hin;
            busy <= w_state_n != IDLE;
            found <= w_found_n;
            exhausted <= w_exhausted_n;
            found_nonce <= w_found_nonce_n;
            found_hash <= w_found_hash_n;
            hash_count <= w_hash_count_n;
        end
    end
endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// tb_sha256_nonce_scheduler: directed checks of the nonce scheduler against a behavioural SHA-256 core
module tb_sha256_nonce_scheduler;
    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [2047:0] KT = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [639:0] GEN = {
        32'h01000000, 256'h0,
        256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
        32'h29ab5f49, 32'hffff001d, 32'h00000000
    };
    localparam logic [255:0] TGT = {32'h0, 32'hffff0000, 192'h0};
    localparam logic [255:0] GEN_HASH = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
    logic clk, reset_n, go, abort, core_start, core_done, busy, found, exhausted;
    logic [639:0] header;
    logic [31:0] nonce_start, nonce_end, found_nonce, hash_count;
    logic [255:0] target, core_hin, core_hout, found_hash;
    logic [511:0] core_block;
    sha256_nonce_scheduler dut (
        .clk(clk), .reset_n(reset_n), .go(go), .abort(abort), .header(header),
        .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
        .core_start(core_start), .core_block(core_block), .core_hin(core_hin),
        .core_done(core_done), .core_hout(core_hout), .busy(busy), .found(found),
        .exhausted(exhausted), .found_nonce(found_nonce), .found_hash(found_hash),
        .hash_count(hash_count)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
                 + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[2047-32*i -: 32] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction
    // behavioural compression core with adjustable latency
    int lat = 3;
    int cnt;
    logic cbusy;
    logic [511:0] blk_q;
    logic [255:0] hin_q;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cbusy <= 1'b0; cnt <= 0; core_done <= 1'b0; core_hout <= '0; blk_q <= '0; hin_q <= '0;
        end else begin
            core_done <= 1'b0;
            if (core_start && !cbusy) begin
                cbusy <= 1'b1; cnt <= lat; blk_q <= core_block; hin_q <= core_hin;
            end else if (cbusy) begin
                if (cnt == 1) begin
                    core_done <= 1'b1; core_hout <= sha_compress(hin_q, blk_q); cbusy <= 1'b0;
                end
                cnt <= cnt - 1;
            end
        end
    end
    int n_starts = 0;
    int tn = 0;
    int dn = 0;
    logic [31:0] tlog [256];
    always @(posedge clk) begin
        if (core_start) begin
            n_starts <= n_starts + 1;
            if (core_hin != IV) begin
                tlog[tn[7:0]] <= core_block[415:384];
                tn <= tn + 1;
            end
            if (core_block[63:0] == 64'd256) dn <= dn + 1;
        end
    end
    int n_chk = 0;
    int n_err = 0;
    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic start_job(input logic [639:0] h, input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] t);
        @(negedge clk);
        header = h; nonce_start = ns; nonce_end = ne; target = t; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask
    task automatic wait_idle(input string tag, input int lim);
        int n = 0;
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 256'(n < lim), 256'd1);
    endtask
    task automatic genesis(input string tag);
        start_job(GEN, 32'h7c2bac1c, 32'h7c2bac1e, TGT);
        chk({tag, "_busy"}, 256'(busy), 256'd1);
        chk({tag, "_start"}, 256'(core_start), 256'd1);
        chk({tag, "_mid_hin"}, core_hin, IV);
        chk({tag, "_mid_blk"}, core_block[511:256], GEN[639:384]);
        wait_idle(tag, 400);
        chk({tag, "_found"}, 256'(found), 256'd1);
        chk({tag, "_exh"}, 256'(exhausted), 256'd0);
        chk({tag, "_nonce"}, 256'(found_nonce), 256'h7c2bac1d);
        chk({tag, "_hash"}, found_hash, GEN_HASH);
        chk({tag, "_count"}, 256'(hash_count), 256'd2);
    endtask
    int s0, t0, d0, n;
    initial begin
        reset_n = 1'b0; go = 1'b0; abort = 1'b0; header = '0;
        nonce_start = '0; nonce_end = '0; target = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_found", 256'(found), 256'd0);
        chk("rst_exh", 256'(exhausted), 256'd0);
        chk("rst_start", 256'(core_start), 256'd0);
        chk("rst_block", core_block[511:256], 256'd0);
        chk("rst_hin", core_hin, 256'd0);
        chk("rst_hash", found_hash, 256'd0);
        chk("rst_count", 256'(hash_count), 256'd0);
        reset_n = 1'b1;
        genesis("gen");
        s0 = n_starts;
        start_job(GEN, 32'h7c2bac1e, 32'h7c2bac20, TGT);
        wait_idle("exh", 400);
        chk("exh_starts", 256'(n_starts - s0), 256'd7);
        chk("exh_flag", 256'(exhausted), 256'd1);
        chk("exh_found", 256'(found), 256'd0);
        chk("exh_count", 256'(hash_count), 256'd3);
        t0 = tn;
        start_job(GEN, 32'hffffffff, 32'h00000001, 256'd0);
        repeat (4) @(negedge clk);
        header = '0; nonce_start = 32'h12345678; nonce_end = 32'h12345678; target = '1; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_idle("wrap", 400);
        chk("wrap_tn", 256'(tn - t0), 256'd3);
        chk("wrap_n0", 256'(tlog[8'(t0)]), 256'hffffffff);
        chk("wrap_n1", 256'(tlog[8'(t0 + 1)]), 256'h00000000);
        chk("wrap_n2", 256'(tlog[8'(t0 + 2)]), 256'h01000000);
        chk("wrap_exh", 256'(exhausted), 256'd1);
        chk("wrap_found", 256'(found), 256'd0);
        chk("wrap_count", 256'(hash_count), 256'd3);
        @(negedge clk);
        go = 1'b1; abort = 1'b1;
        @(negedge clk);
        go = 1'b0; abort = 1'b0;
        chk("goab_busy", 256'(busy), 256'd0);
        chk("goab_start", 256'(core_start), 256'd0);
        lat = 66;
        t0 = tn;
        start_job(GEN, 32'h7c2bac1c, 32'h7c2bac1e, TGT);
        n = 0;
        while (tn == t0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("abt_tstart", 256'(n < 300), 256'd1);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        s0 = n_starts;
        chk("abt_drain_busy", 256'(busy), 256'd1);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("abt_done", 256'(n < 100), 256'd1);
        chk("abt_drain_len", 256'(n >= 55), 256'd1);
        chk("abt_nostart", 256'(n_starts - s0), 256'd0);
        chk("abt_found", 256'(found), 256'd0);
        chk("abt_exh", 256'(exhausted), 256'd0);
        lat = 3;
        genesis("regen");
        d0 = dn;
        start_job(GEN, 32'h7c2bac1c, 32'h7c2bac1e, TGT);
        n = 0;
        while (dn == d0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rmid_dstart", 256'(n < 200), 256'd1);
        reset_n = 1'b0;
        #1;
        chk("rmid_busy", 256'(busy), 256'd0);
        chk("rmid_block", core_block[255:0], 256'd0);
        chk("rmid_hin", core_hin, 256'd0);
        chk("rmid_hash", found_hash, 256'd0);
        chk("rmid_found", 256'(found), 256'd0);
        chk("rmid_nonce", 256'(found_nonce), 256'd0);
        @(negedge clk);
        reset_n = 1'b1;
        genesis("post_rst");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sha256_nonce_scheduler.md
# sha256_nonce_scheduler

Controller that sequences the shared SHA-256 compression core through a Bitcoin-style double-SHA-256 nonce search over an 80-byte block header. It computes the first-block midstate once per job. For each nonce it then issues two core operations: header tail plus nonce, then the second hash of the digest. It compares each result to a target and stops on a hit, on exhaustion of the nonce range, or on abort. It sits between the host/SPI front end (job registers) and the compression core.

## Interface
Parameters:
- NONCE_W, 32, nonce width (fixed by header format; not meant to be overridden)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- go  in  1  one-cycle job start; sampled only in IDLE
- abort  in  1  one-cycle job cancel; sampled in any state
- header  in  640  header bytes, byte 0 = header[639:632]; nonce field header[31:0] is ignored
- nonce_start  in  32  first nonce tried
- nonce_end  in  32  last nonce tried (inclusive)
- target  in  256  hit when byte-reversed final digest <= target (unsigned)
- core_start  out  1  one-cycle pulse launching a compression
- core_block  out  512  message block, held stable from core_start until core_done
- core_hin  out  256  chaining value in, held stable likewise
- core_done  in  1  one-cycle pulse; core_hout valid this cycle
- core_hout  in  256  chaining value out (feed-forward addition already applied)
- busy  out  1  job in progress (not IDLE)
- found  out  1  sticky hit flag for last job
- exhausted  out  1  sticky no-hit flag for last job
- found_nonce  out  32  nonce of hit
- found_hash  out  256  byte-reversed final digest of hit
- hash_count  out  32  nonces fully checked in current/last job

## Operation
- States: IDLE, MID_START, MID_WAIT, T_START, T_WAIT, D_START, D_WAIT, CHECK, DRAIN.
- IDLE: go=1 and abort=0 -> latch header, nonce_start, nonce_end, target. Clear found, exhausted, hash_count. nonce <= nonce_start. Go to MID_START.
- *_START states last exactly one cycle with core_start=1, then move to the matching *_WAIT.
- *_WAIT states hold until core_done. core_done outside a WAIT/DRAIN state is ignored.
- MID: block = header[639:128], hin = IV. On done, midstate <= core_hout, then T_START.
- T: block = {header[127:32], bswap32(nonce), 1'b1, 319'b0, 64'd640}, hin = midstate. On done, digest1 <= core_hout, then D_START.
- D: block = {digest1, 1'b1, 191'b0, 64'd256}, hin = IV. On done, digest2 <= core_hout, then CHECK.
- CHECK, one cycle; hash_count increments:
  - If bswap256(digest2) <= target: found=1, found_nonce=nonce, found_hash=bswap256(digest2), then IDLE.
  - Else if nonce == nonce_end: exhausted=1, then IDLE.
  - Else nonce <= nonce+1 (mod 2^32), then T_START.
- Wrap-around: nonce_start > nonce_end searches through 0xFFFFFFFF -> 0. nonce_start == nonce_end checks exactly one nonce.
- abort:
  - In a START state or CHECK: go to IDLE. No core_start is issued. found and exhausted stay 0.
  - In a WAIT state: go to DRAIN. DRAIN waits for core_done, then IDLE. busy stays 1 through DRAIN.
  - In IDLE: abort wins over a simultaneous go, so no job starts.
- go while busy is ignored.
- Job inputs may change after go without effect.

## Timing
- Reset: state IDLE; all outputs 0, including core_block, core_hin, found_hash, and hash_count.
- busy rises the cycle after go.
- The first core_start occurs 1 cycle after go.
- Per nonce: 2 core latencies + 5 cycles (T_START, D_START, CHECK, and one cycle each of WAIT entry after done).
- found/exhausted rise in the cycle after CHECK; busy falls in that same cycle.
- All outputs are registered.
- reset_n asserted mid-job: immediate return to the reset state; the core is reset on the same reset_n.

## Structure
- sha256_pkg: IV constant (6a09e667 … 5be0cd19), state enum type, bswap32/bswap256 functions, padding length constants 640/256.
- One sub-module, sha256_block_fmt: combinational mux building core_block/core_hin from state, header, nonce, digest1, midstate.
- Scheduler FSM, nonce counter, and compare live in the top module.

## Test plan
- Genesis header, nonce_start=0x7C2BAC1C, nonce_end=0x7C2BAC1E, target=0x00000000FFFF0000…0 -> found=1, found_nonce=0x7C2BAC1D, found_hash=000000000019d668…0a8ce26f, hash_count=2.
- Same header, range 0x7C2BAC1E–0x7C2BAC20 -> exhausted=1, found=0, hash_count=3, exactly 7 core_start pulses (1 MID + 3×2).
- nonce_start=0xFFFFFFFF, nonce_end=0x00000001, target=0 -> core_block nonce fields 0xFFFFFFFF, 0x00000000, 0x01000000 (byte-swapped), then exhausted, hash_count=3.
- abort during T_WAIT with core latency 66 -> no further core_start, busy=1 until core_done, then IDLE. found=exhausted=0. A following go restarts cleanly.
- go and abort in the same IDLE cycle -> stays IDLE. go pulse while busy -> no effect on nonce sequence.
- reset_n low during D_WAIT -> all outputs 0 in the same cycle. After release, go runs the full genesis scenario correctly.
